// File: rtl/spi_demux_router.sv
// -----------------------------------------------------------------------------
// spi_demux_router
//
// Purpose:
//   Registered 1:NCH demultiplexer for the SPI receive datapath. It takes a
//   valid/ready byte stream and steers each word into one of NCH single-entry
//   channel buffers. Each buffer has its own valid/ready handshake. A packet
//   (first word up to and including the word flagged `last`) is locked to the
//   channel selected on its first word. Words addressed to a channel index
//   >= NCH are accepted and discarded, and a saturating drop counter records
//   each one.
//
// Parameters:
//   DW   data word width
//   NCH  number of output channels (2..16)
//   SW   select width, 2**SW >= NCH
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_data    input word
//   in_sel     destination channel, only looked at while idle
//   in_last    final word of a packet
//   in_valid   input word present
//   in_ready   input word accepted when high together with in_valid
//   out_data   channel k data at [k*DW +: DW]
//   out_last   per-channel last flag of the buffered word
//   out_valid  per-channel buffer full
//   out_ready  per-channel consumer ready
//   busy       high while a packet is locked
//   drop_cnt   saturating count of discarded out-of-range words
//
// Build option:
//   SPI_DEMUX_HIZ_EN  when defined, an empty channel drives its out_data slice
//                     and out_last bit to z (legacy shared-bus consumers).
//                     When undefined, an empty channel drives zeros.
// -----------------------------------------------------------------------------
module spi_demux_router #(
    parameter int DW  = 8,
    parameter int NCH = 2,
    parameter int SW  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DW-1:0]     in_data,
    input  logic [SW-1:0]     in_sel,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [NCH*DW-1:0] out_data,
    output logic [NCH-1:0]    out_last,
    output logic [NCH-1:0]    out_valid,
    input  logic [NCH-1:0]    out_ready,
    output logic              busy,
    output logic [7:0]        drop_cnt
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_cur_sel;
    logic            r_busy;
    logic [7:0]      r_drop_cnt;

    logic [SW-1:0]   w_target;
    logic [NCH-1:0]  w_hit;
    logic [NCH-1:0]  w_room;
    logic [NCH-1:0]  w_load;
    logic [NCH-1:0]  w_full;
    logic            w_in_range;
    logic            w_accept;

    // While a packet is locked the stored select wins; in_sel is ignored.
    assign w_target = (r_state == ST_LOCK) ? r_cur_sel : in_sel;

    // One-hot decode of the target. A select >= NCH matches no channel, so
    // the OR of the decode doubles as the in-range test.
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi = gi + 1) begin : g_decode
            assign w_hit[gi]  = (w_target == SW'(gi));
            // Room if empty, or if the consumer drains this very cycle.
            assign w_room[gi] = ~w_full[gi] | out_ready[gi];
        end
    endgenerate

    assign w_in_range = |w_hit;
    // Out-of-range words are always taken so they can be discarded.
    assign in_ready   = ~w_in_range | (|(w_hit & w_room));
    assign w_accept   = in_valid & in_ready;
    assign w_load     = w_hit & {NCH{w_accept}};

    // Packet-routing FSM; busy is registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cur_sel <= '0;
            r_busy    <= 1'b0;
        end else if (w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    if (!in_last) begin
                        r_state   <= ST_LOCK;
                        r_cur_sel <= in_sel;
                        r_busy    <= 1'b1;
                    end
                end
                ST_LOCK: begin
                    if (in_last) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Drop counter sticks at 255 rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= 8'd0;
        end else if (w_accept && !w_in_range && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign busy     = r_busy;
    assign drop_cnt = r_drop_cnt;

    // Per-channel one-entry buffers.
    generate
        for (gi = 0; gi < NCH; gi = gi + 1) begin : g_chan
            logic          r_full;
            logic          r_last;
            logic [DW-1:0] r_data;

            // A load takes priority over a drain, so a simultaneous
            // drain+load leaves the buffer full with the new word.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_full <= 1'b0;
                    r_last <= 1'b0;
                    r_data <= '0;
                end else if (w_load[gi]) begin
                    r_full <= 1'b1;
                    r_last <= in_last;
                    r_data <= in_data;
                end else if (r_full && out_ready[gi]) begin
                    r_full <= 1'b0;
                end
            end

            assign w_full[gi]    = r_full;
            assign out_valid[gi] = r_full;

`ifdef SPI_DEMUX_HIZ_EN
            assign out_data[gi*DW +: DW] = r_full ? r_data : {DW{1'bz}};
            assign out_last[gi]          = r_full ? r_last : 1'bz;
`else
            assign out_data[gi*DW +: DW] = r_full ? r_data : {DW{1'b0}};
            assign out_last[gi]          = r_full & r_last;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_spi_demux_router.sv
module tb_spi_demux_router;

    logic clk;
    logic rst_n;

    // DUT A: NCH=2, SW=1
    logic [7:0]  a_in_data;
    logic [0:0]  a_in_sel;
    logic        a_in_last;
    logic        a_in_valid;
    logic        a_in_ready;
    logic [15:0] a_out_data;
    logic [1:0]  a_out_last;
    logic [1:0]  a_out_valid;
    logic [1:0]  a_out_ready;
    logic        a_busy;
    logic [7:0]  a_drop_cnt;

    // DUT B: NCH=3, SW=2 (select 3 is out of range)
    logic [7:0]  b_in_data;
    logic [1:0]  b_in_sel;
    logic        b_in_last;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [23:0] b_out_data;
    logic [2:0]  b_out_last;
    logic [2:0]  b_out_valid;
    logic [2:0]  b_out_ready;
    logic        b_busy;
    logic [7:0]  b_drop_cnt;

    int n_tests;
    int n_fail;

    spi_demux_router #(.DW(8), .NCH(2), .SW(1)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (a_in_data),
        .in_sel    (a_in_sel),
        .in_last   (a_in_last),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .out_data  (a_out_data),
        .out_last  (a_out_last),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .busy      (a_busy),
        .drop_cnt  (a_drop_cnt)
    );

    spi_demux_router #(.DW(8), .NCH(3), .SW(2)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (b_in_data),
        .in_sel    (b_in_sel),
        .in_last   (b_in_last),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .out_data  (b_out_data),
        .out_last  (b_out_last),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .busy      (b_busy),
        .drop_cnt  (b_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        a_in_data   = 8'h00; a_in_sel = 1'b0; a_in_last = 1'b0; a_in_valid = 1'b0;
        a_out_ready = 2'b11;
        b_in_data   = 8'h00; b_in_sel = 2'd0; b_in_last = 1'b0; b_in_valid = 1'b0;
        b_out_ready = 3'b111;
        #12;
        n_tests++;
        if (a_out_valid !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b want 00", a_out_valid); end
        n_tests++;
        if (a_out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h want 0000", a_out_data); end
        n_tests++;
        if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        n_tests++;
        if (a_drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", a_drop_cnt); end
        n_tests++;
        if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", a_in_ready); end
        rst_n = 1'b1;
        tick();
        $display("[TB] reset released");
    endtask

    task automatic test_single();
        a_in_sel = 1'b1; a_in_last = 1'b1; a_in_data = 8'hA5; a_in_valid = 1'b1;
        #1;
        n_tests++;
        if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", a_in_ready); end
        tick();
        a_in_valid = 1'b0;
        n_tests++;
        if (a_out_valid !== 2'b10) begin n_fail++; $display("FAIL single_valid: got %b want 10", a_out_valid); end
        n_tests++;
        if (a_out_data !== 16'hA500) begin n_fail++; $display("FAIL single_data: got %h want a500", a_out_data); end
        n_tests++;
        if (a_out_last !== 2'b10) begin n_fail++; $display("FAIL single_last: got %b want 10", a_out_last); end
        n_tests++;
        if (a_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b want 0", a_busy); end
        tick();
        n_tests++;
        if (a_out_valid !== 2'b00) begin n_fail++; $display("FAIL single_drain: got %b want 00", a_out_valid); end
        $display("[TB] single word 0xa5 -> ch1");
    endtask

    task automatic test_packet();
        logic [7:0] words [3];
        logic [0:0] sels  [3];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        sels[0]  = 1'b0;  sels[1]  = 1'b1;  sels[2]  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_in_data = words[i]; a_in_sel = sels[i]; a_in_last = (i == 2); a_in_valid = 1'b1;
            tick();
            n_tests++;
            if (a_out_valid !== 2'b01 || a_out_data[7:0] !== words[i]) begin
                n_fail++;
                $display("FAIL packet_word%0d: got valid %b data %h want valid 01 data %h",
                         i, a_out_valid, a_out_data[7:0], words[i]);
            end
            n_tests++;
            if (a_busy !== (i != 2)) begin
                n_fail++; $display("FAIL packet_busy%0d: got %b want %b", i, a_busy, (i != 2));
            end
            $display("[TB] packet word %0d = %h on ch0", i, a_out_data[7:0]);
        end
        n_tests++;
        if (a_out_last !== 2'b01) begin n_fail++; $display("FAIL packet_last: got %b want 01", a_out_last); end
        a_in_valid = 1'b0;
        tick();
        n_tests++;
        if (a_out_valid !== 2'b00) begin n_fail++; $display("FAIL packet_drain: got %b want 00", a_out_valid); end
    endtask

    task automatic test_stall();
        a_out_ready = 2'b10;
        a_in_sel = 1'b0; a_in_last = 1'b1; a_in_data = 8'h11; a_in_valid = 1'b1;
        tick();
        a_in_data = 8'h99;
        n_tests++;
        if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_low: got %b want 0", a_in_ready); end
        tick();
        n_tests++;
        if (a_out_valid !== 2'b01 || a_out_data[7:0] !== 8'h11) begin
            n_fail++; $display("FAIL stall_hold: got valid %b data %h want 01 11", a_out_valid, a_out_data[7:0]);
        end
        a_out_ready = 2'b11;
        #1;
        n_tests++;
        if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready_comb: got %b want 1", a_in_ready); end
        @(posedge clk); #1;
        a_out_ready = 2'b10;
        a_in_valid  = 1'b0;
        n_tests++;
        if (a_out_valid !== 2'b01 || a_out_data[7:0] !== 8'h99) begin
            n_fail++; $display("FAIL stall_reload: got valid %b data %h want 01 99", a_out_valid, a_out_data[7:0]);
        end
        tick();
        n_tests++;
        if (a_out_data[7:0] !== 8'h99) begin n_fail++; $display("FAIL stall_keep: got %h want 99", a_out_data[7:0]); end
        a_out_ready = 2'b11;
        tick();
        $display("[TB] stall: 0x11 drained, 0x99 loaded same cycle");
    endtask

    task automatic test_drop();
        int bad_ready;
        int bad_cnt;
        int exp_cnt;
        bad_ready = 0;
        bad_cnt   = 0;
        b_in_sel = 2'd3; b_in_last = 1'b1; b_in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            b_in_data = 8'(i);
            #1;
            if (b_in_ready !== 1'b1) bad_ready++;
            tick();
            exp_cnt = (i + 1 > 255) ? 255 : i + 1;
            if (b_drop_cnt !== 8'(exp_cnt) || b_out_valid !== 3'b000) bad_cnt++;
        end
        n_tests++;
        if (bad_ready != 0) begin n_fail++; $display("FAIL drop_ready: %0d cycles low want 0", bad_ready); end
        n_tests++;
        if (bad_cnt != 0) begin n_fail++; $display("FAIL drop_count: %0d bad cycles want 0", bad_cnt); end
        n_tests++;
        if (b_drop_cnt !== 8'd255) begin n_fail++; $display("FAIL drop_sat: got %0d want 255", b_drop_cnt); end
        $display("[TB] drop: 300 words to sel 3, drop_cnt=%0d", b_drop_cnt);
        // Out-of-range packet: in-range select mid-packet must still be dropped.
        b_in_sel = 2'd3; b_in_last = 1'b0;
        tick();
        b_in_sel = 2'd0;
        tick();
        n_tests++;
        if (b_busy !== 1'b1 || b_out_valid !== 3'b000) begin
            n_fail++; $display("FAIL drop_packet: got busy %b valid %b want 1 000", b_busy, b_out_valid);
        end
        b_in_last = 1'b1;
        tick();
        b_in_valid = 1'b0;
        n_tests++;
        if (b_busy !== 1'b0 || b_out_valid !== 3'b000) begin
            n_fail++; $display("FAIL drop_packet_end: got busy %b valid %b want 0 000", b_busy, b_out_valid);
        end
        // In-range word on channel 2.
        b_in_sel = 2'd2; b_in_data = 8'h5C; b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        n_tests++;
        if (b_out_valid !== 3'b100 || b_out_data !== 24'h5C0000) begin
            n_fail++; $display("FAIL ch2_route: got valid %b data %h want 100 5c0000", b_out_valid, b_out_data);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        a_in_sel = 1'b0; a_in_last = 1'b0; a_in_data = 8'h55; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        n_tests++;
        if (a_busy !== 1'b1) begin n_fail++; $display("FAIL midrst_lock: got %b want 1", a_busy); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (a_busy !== 1'b0 || a_out_valid !== 2'b00 || a_out_data !== 16'h0000) begin
            n_fail++; $display("FAIL midrst_async: got busy %b valid %b data %h want 0 00 0000",
                               a_busy, a_out_valid, a_out_data);
        end
        n_tests++;
        if (b_drop_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst_drop: got %0d want 0", b_drop_cnt); end
        #2;
        rst_n = 1'b1;
        tick();
        a_in_sel = 1'b1; a_in_last = 1'b1; a_in_data = 8'h66; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        n_tests++;
        if (a_out_valid !== 2'b10 || a_out_data[15:8] !== 8'h66 || a_busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_next: got valid %b data %h busy %b want 10 66 0",
                               a_out_valid, a_out_data[15:8], a_busy);
        end
        tick();
        $display("[TB] mid-packet reset aborted lock");
    endtask

    task automatic test_empty_drive();
        a_out_ready = 2'b01;
        a_in_sel = 1'b1; a_in_last = 1'b0; a_in_data = 8'h77; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        n_tests++;
        if (a_out_data[15:8] !== 8'h77) begin n_fail++; $display("FAIL empty_full_ch: got %h want 77", a_out_data[15:8]); end
`ifdef SPI_DEMUX_HIZ_EN
        n_tests++;
        if (a_out_data[7:0] !== 8'hzz || a_out_last[0] !== 1'bz) begin
            n_fail++; $display("FAIL empty_hiz: got %h last %b want zz z", a_out_data[7:0], a_out_last[0]);
        end
`else
        n_tests++;
        if (a_out_data[7:0] !== 8'h00 || a_out_last[0] !== 1'b0) begin
            n_fail++; $display("FAIL empty_zero: got %h last %b want 00 0", a_out_data[7:0], a_out_last[0]);
        end
`endif
        a_out_ready = 2'b11;
        tick();
        $display("[TB] empty channel drive checked");
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_single();
        test_packet();
        test_stall();
        test_drop();
        test_reset_mid();
        test_empty_drive();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
